// File: rtl/divider_pkg.sv
// Shared constants, state encoding and two's-complement helper for the divider.
package divider_pkg;

  localparam int WIDTH     = 32;
  localparam int ITER_LAST = WIDTH - 1;
  localparam int CNT_W     = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  localparam logic [WIDTH-1:0] DBZ_Q = '1;

  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

endpackage

// File: rtl/full_adder1b.sv
// 1-bit ripple full adder, the building block shared with the multiplier.
module full_adder1b (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/subtractor33b.sv
// Combinational (WIDTH+1)-bit A-B as a full-adder ripple chain with B inverted and carry-in 1.
module subtractor33b
  import divider_pkg::*;
(
  input  logic [WIDTH:0] a_i,
  input  logic [WIDTH:0] b_i,
  output logic [WIDTH:0] diff_o,
  output logic           nonneg_o
);

  logic [WIDTH+1:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_bit
    full_adder1b u_fa (
      .a_i  (a_i[i]),
      .b_i  (~b_i[i]),
      .ci_i (carry[i]),
      .s_o  (diff_o[i]),
      .co_o (carry[i+1])
    );
  end

  // Carry out of an unsigned subtract means no borrow, i.e. a_i >= b_i.
  assign nonneg_o = carry[WIDTH+1];

endmodule

// File: rtl/divider32b.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Define DIVIDER_SIGNED_EN for two's-complement operands (truncating toward zero).
module divider32b
  import divider_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A_32b,
  input  logic [WIDTH-1:0] B_32b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q_32b,
  output logic [WIDTH-1:0] R_32b,
  output logic             div_by_zero
);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             zdiv_q, zdiv_d;
  logic [WIDTH-1:0] q_out_q, q_out_d;
  logic [WIDTH-1:0] r_out_q, r_out_d;
  logic             dbz_out_q, dbz_out_d;
`ifdef DIVIDER_SIGNED_EN
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
`endif

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             nonneg;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;
  logic             diff_msb_unused;

  assign trial = {rem_q, dvd_q[WIDTH-1]};

  subtractor33b u_sub (
    .a_i      (trial),
    .b_i      ({1'b0, dvs_q}),
    .diff_o   (diff),
    .nonneg_o (nonneg)
  );

  // rem < divisor keeps the difference below 2^WIDTH whenever it is non-negative.
  assign diff_msb_unused = diff[WIDTH];
  assign rem_next = nonneg ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_next = {quo_q[WIDTH-2:0], nonneg};

`ifdef DIVIDER_SIGNED_EN
  assign q_final = qneg_q ? neg2c(quo_next) : quo_next;
  assign r_final = rneg_q ? neg2c(rem_next) : rem_next;
`else
  assign q_final = quo_next;
  assign r_final = rem_next;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    zdiv_d    = zdiv_q;
    q_out_d   = q_out_q;
    r_out_d   = r_out_q;
    dbz_out_d = dbz_out_q;
`ifdef DIVIDER_SIGNED_EN
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          cnt_d   = CNT_W'(ITER_LAST);
          rem_d   = '0;
          quo_d   = '0;
          zdiv_d  = (B_32b == '0);
`ifdef DIVIDER_SIGNED_EN
          // A zero divisor keeps the raw dividend so it can be returned as the remainder.
          dvd_d   = ((B_32b == '0) || !A_32b[WIDTH-1]) ? A_32b : neg2c(A_32b);
          dvs_d   = B_32b[WIDTH-1] ? neg2c(B_32b) : B_32b;
          qneg_d  = A_32b[WIDTH-1] ^ B_32b[WIDTH-1];
          rneg_d  = A_32b[WIDTH-1];
`else
          dvd_d   = A_32b;
          dvs_d   = B_32b;
`endif
        end
      end
      CALC: begin
        if (zdiv_q) begin
          state_d   = DONE;
          q_out_d   = DBZ_Q;
          r_out_d   = dvd_q;
          dbz_out_d = 1'b1;
        end else begin
          rem_d = rem_next;
          quo_d = quo_next;
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
          if (cnt_q == '0) begin
            state_d   = DONE;
            q_out_d   = q_final;
            r_out_d   = r_final;
            dbz_out_d = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      zdiv_q    <= 1'b0;
      q_out_q   <= '0;
      r_out_q   <= '0;
      dbz_out_q <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      zdiv_q    <= zdiv_d;
      q_out_q   <= q_out_d;
      r_out_q   <= r_out_d;
      dbz_out_q <= dbz_out_d;
`ifdef DIVIDER_SIGNED_EN
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
`endif
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign Q_32b       = q_out_q;
  assign R_32b       = r_out_q;
  assign div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_divider32b.sv
// Self-checking bench for divider32b: arithmetic reference model plus directed vectors.
module tb_divider32b;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A_32b;
  logic [31:0] B_32b;
  logic        busy;
  logic        done;
  logic [31:0] Q_32b;
  logic [31:0] R_32b;
  logic        div_by_zero;

  divider32b dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A_32b       (A_32b),
    .B_32b       (B_32b),
    .busy        (busy),
    .done        (done),
    .Q_32b       (Q_32b),
    .R_32b       (R_32b),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          due;
  } exp_t;

  exp_t        exq[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          busy_from = 1;
  int          busy_to = 0;
  bit          chk_en = 1'b0;
  logic [31:0] hold_q = '0;
  logic [31:0] hold_r = '0;
  logic        hold_z = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division, truncating toward zero in the signed build.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    z = (b == 32'd0);
    if (z) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      sa = longint'($signed(a));
      sb = longint'($signed(b));
`else
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
`endif
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endtask

  // One clock of stimulus, applied 2 time units after the rising edge.
  task automatic drive_cycle(input logic r, input logic s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   lat;
    rst   = r;
    start = s;
    A_32b = a;
    B_32b = b;
    if (!r && s && cyc > busy_to) begin
      model(a, b, e.q, e.r, e.z);
      lat       = e.z ? 1 : 32;
      e.due     = cyc + 1 + lat;
      busy_from = cyc + 1;
      busy_to   = cyc + 1 + lat;
      exq.push_back(e);
    end
    @(posedge clk);
    #2;
    if (r) begin
      exq.delete();
      hold_q    = '0;
      hold_r    = '0;
      hold_z    = 1'b0;
      busy_from = 1;
      busy_to   = 0;
    end
  endtask

  task automatic wait_done();
    int n0;
    n0 = done_cnt;
    for (int i = 0; i < 40; i++) begin
      if (done_cnt > n0) return;
      drive_cycle(1'b0, 1'b0, 32'd0, 32'd0);
    end
    n_chk++;
    n_fail++;
    $display("FAIL wait_done: no done within 40 cycles, got %0d expected %0d", done_cnt, n0 + 1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic ez);
    drive_cycle(1'b0, 1'b1, a, b);
    wait_done();
    chk("lit_Q", Q_32b, eq);
    chk("lit_R", R_32b, er);
    chk("lit_dbz", {31'd0, div_by_zero}, {31'd0, ez});
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, (cyc >= busy_from && cyc <= busy_to)});
      if (exq.size() > 0 && exq[0].due == cyc) begin
        exp_t e;
        e = exq.pop_front();
        chk("done", {31'd0, done}, 32'd1);
        chk("Q", Q_32b, e.q);
        chk("R", R_32b, e.r);
        chk("dbz", {31'd0, div_by_zero}, {31'd0, e.z});
        hold_q = e.q;
        hold_r = e.r;
        hold_z = e.z;
      end else begin
        chk("done_idle", {31'd0, done}, 32'd0);
        chk("Q_hold", Q_32b, hold_q);
        chk("R_hold", R_32b, hold_r);
        chk("dbz_hold", {31'd0, div_by_zero}, {31'd0, hold_z});
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    A_32b = '0;
    B_32b = '0;
    @(posedge clk);
    #2;
    drive_cycle(1'b1, 1'b0, 32'd0, 32'd0);
    drive_cycle(1'b1, 1'b1, 32'd9, 32'd3);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_Q", Q_32b, 32'd0);
    chk("rst_R", R_32b, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    chk_en = 1'b1;

    run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op(32'h1234_5678, 32'h1234_5679, 32'd0, 32'h1234_5678, 1'b0);
    run_op(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    run_op(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);

    // A second start at T10 must be ignored.
    drive_cycle(1'b0, 1'b1, 32'd1000, 32'd10);
    for (int i = 0; i < 9; i++) drive_cycle(1'b0, 1'b0, 32'd0, 32'd0);
    drive_cycle(1'b0, 1'b1, 32'd55, 32'd5);
    wait_done();
    chk("ign_Q", Q_32b, 32'd100);
    chk("ign_R", R_32b, 32'd0);

    // Start held high: re-accepted at T34, never during DONE.
    for (int i = 0; i < 40; i++) drive_cycle(1'b0, 1'b1, 32'd200, 32'd9);
    wait_done();
    chk("held_Q", Q_32b, 32'd22);
    chk("held_R", R_32b, 32'd2);

    // Reset at T10 discards the operation in flight.
    drive_cycle(1'b0, 1'b1, 32'd1000, 32'd3);
    for (int i = 0; i < 9; i++) drive_cycle(1'b0, 1'b0, 32'd0, 32'd0);
    drive_cycle(1'b1, 1'b0, 32'd0, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_Q", Q_32b, 32'd0);
    chk("mrst_R", R_32b, 32'd0);
    chk("mrst_dbz", {31'd0, div_by_zero}, 32'd0);
    run_op(32'd81, 32'd9, 32'd9, 32'd0, 1'b0);

`ifdef DIVIDER_SIGNED_EN
    run_op(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_op(32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    run_op(32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
`else
    run_op(32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
`endif

    drive_cycle(1'b0, 1'b0, 32'd0, 32'd0);
    drive_cycle(1'b0, 1'b0, 32'd0, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
